// File: rtl/mem_stage_responder_if.sv
// +--------------------------------------------------------------------------+
// | mem_stage_responder_if : sequencer request/response and data-bus bundle  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

interface mem_stage_responder_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  req;
    logic                  req_we;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [DATA_W/8-1:0]   req_be;
    logic                  stall;
    logic                  done;
    logic [DATA_W-1:0]     rdata;
    logic                  err;
    logic                  bus_valid;
    logic                  bus_we;
    logic [ADDR_W-1:0]     bus_addr;
    logic [DATA_W-1:0]     bus_wdata;
    logic [DATA_W/8-1:0]   bus_be;
    logic                  bus_ready;
    logic [DATA_W-1:0]     bus_rdata;

    modport slave (
        input  req, req_we, req_addr, req_wdata, req_be, bus_ready, bus_rdata,
        output stall, done, rdata, err,
        output bus_valid, bus_we, bus_addr, bus_wdata, bus_be
    );

    modport master (
        output req, req_we, req_addr, req_wdata, req_be, bus_ready, bus_rdata,
        input  stall, done, rdata, err,
        input  bus_valid, bus_we, bus_addr, bus_wdata, bus_be
    );
endinterface

`default_nettype wire

// File: rtl/mem_stage_responder.sv
// +--------------------------------------------------------------------------+
// | mem_stage_responder : MEM-stage access strobe -> one valid/ready bus txn |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module mem_stage_responder #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  wire logic             clk,
    input  wire logic             reset_n,
    mem_stage_responder_if.slave  mif
);
    localparam int                BE_W       = DATA_W / 8;
    localparam logic [BE_W-1:0]   c_BE_ALL   = '1;
    localparam logic [BE_W-1:0]   c_HALF_LO  = BE_W'(4'b0011);
    localparam logic [BE_W-1:0]   c_HALF_HI  = BE_W'(4'b1100);
    localparam logic [7:0]        c_TO_LAST  = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                w_stall;
    logic                w_bus_valid;
    logic                w_done;
    logic                w_misaligned;
    logic                w_timeout;
    logic                w_accept;

    logic                r_we;
    logic [ADDR_W-1:2]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [BE_W-1:0]     r_be;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_err;
    logic [7:0]          r_count;

    assign w_misaligned = (mif.req_be == '0)
                       || ((mif.req_be == c_BE_ALL) && (mif.req_addr[1:0] != 2'b00))
                       || (((mif.req_be == c_HALF_LO) || (mif.req_be == c_HALF_HI))
                           && mif.req_addr[0]);
    assign w_timeout = (r_count == c_TO_LAST);
    assign w_accept  = (r_state == S_IDLE) && mif.req;

    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_stall     = 1'b0;
        w_bus_valid = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (mif.req) w_next = w_misaligned ? S_DONE : S_BUS;
            end
            S_BUS: begin
                w_stall     = 1'b1;
                w_bus_valid = 1'b1;
                if (mif.bus_ready || w_timeout) w_next = S_DONE;
            end
            S_DONE: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Request fields are captured only when accepted in IDLE, so they hold for the whole bus phase.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_count <= 8'd0;
        end else begin
            if (w_accept) begin
                r_we    <= mif.req_we;
                r_addr  <= mif.req_addr[ADDR_W-1:2];
                r_wdata <= mif.req_wdata;
                r_be    <= mif.req_be;
                r_count <= 8'd0;
            end else if ((r_state == S_BUS) && !mif.bus_ready) begin
                r_count <= r_count + 8'd1;
            end

            if ((r_state == S_BUS) && mif.bus_ready && !r_we)
                r_rdata <= mif.bus_rdata;

            if ((w_accept && w_misaligned)
                || ((r_state != S_IDLE) && mif.req)
                || ((r_state == S_BUS) && !mif.bus_ready && w_timeout))
                r_err <= 1'b1;
        end
    end

    assign mif.stall     = w_stall;
    assign mif.done      = w_done;
    assign mif.rdata     = r_rdata;
    assign mif.err       = r_err;
    assign mif.bus_valid = w_bus_valid;
    assign mif.bus_we    = r_we;
    assign mif.bus_addr  = {r_addr, 2'b00};
    assign mif.bus_wdata = r_wdata;
    assign mif.bus_be    = r_be;

endmodule

`default_nettype wire
